// File: rtl/seq_det_pkg.sv
// Shared definitions for the detector time-sharing scheduler: FSM state
// encodings and default frame geometry.
package seq_det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int DEF_FRAME_LEN = 16;
    localparam int DEF_DET_LAT   = 1;

endpackage

// File: rtl/seq_det_sched_rr_arbiter.sv
// Round-robin priority picker: finds the first requesting channel at or
// after the pointer, wrapping around. Purely combinational.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int ID_W = 2
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N_CH-1:0] gnt_next_o,
    output logic [ID_W-1:0] id_o,
    output logic            any_o
);

    // Scan channels starting at the pointer; the first hit wins.
    always_comb begin
        int  idx;
        logic found;
        idx        = 0;
        found      = 1'b0;
        gnt_next_o = '0;
        id_o       = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(ptr_i) + i) % N_CH;
            if (!found && req_i[idx]) begin
                found           = 1'b1;
                gnt_next_o[idx] = 1'b1;
                id_o            = ID_W'(idx);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/seq_det_sched.sv
// Time-shares one 1010 sequence detector among N_CH serial requesters.
// Each frame: clear the detector, stream FRAME_LEN bits of the granted
// channel into it, wait out the detector latency, then report the number
// of z pulses seen together with the channel id.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int DET_LAT   = DEF_DET_LAT,
    parameter int CNT_W     = 5,
    parameter int ID_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic [N_CH-1:0]  bit_in,
    output logic [N_CH-1:0]  gnt,
    output logic             det_x,
    output logic             det_rst,
    input  logic             det_z,
    output logic             done,
    output logic [ID_W-1:0]  done_id,
    output logic [CNT_W-1:0] match_cnt,
    output logic             abort
);

    localparam logic [7:0]      LAST_BIT   = 8'(FRAME_LEN - 1);
    localparam logic [7:0]      FIRST_Z    = 8'(DET_LAT);
    localparam logic [7:0]      LAST_DRAIN = 8'(DET_LAT - 1);
    localparam logic [ID_W-1:0] LAST_CH    = ID_W'(N_CH - 1);

    state_e            state_q;
    logic [ID_W-1:0]   cur_q;
    logic [ID_W-1:0]   ptr_q;
    logic [7:0]        bit_cnt_q;
    logic [CNT_W-1:0]  run_cnt_q;
    logic [N_CH-1:0]   gnt_q;
    logic              det_rst_q;
    logic              done_q;
    logic              abort_q;
    logic [ID_W-1:0]   done_id_q;
    logic [CNT_W-1:0]  match_cnt_q;

    logic [N_CH-1:0]   arb_gnt;
    logic [ID_W-1:0]   arb_id;
    logic              arb_any;

    logic              cur_req;
    logic              z_window;
    logic [CNT_W-1:0]  run_cnt_d;
    logic [ID_W-1:0]   ptr_d;

    rr_arbiter #(
        .N_CH (N_CH),
        .ID_W (ID_W)
    ) u_arb (
        .req_i      (req),
        .ptr_i      (ptr_q),
        .gnt_next_o (arb_gnt),
        .id_o       (arb_id),
        .any_o      (arb_any)
    );

    // z pulses only count once the detector output reflects bits of this
    // frame: from bit index DET_LAT onward in RUN, and throughout DRAIN.
    always_comb begin
        cur_req   = req[cur_q];
        z_window  = ((state_q == ST_RUN) && (bit_cnt_q >= FIRST_Z)) ||
                    (state_q == ST_DRAIN);
        run_cnt_d = run_cnt_q;
        if (z_window && det_z && (run_cnt_q != '1))
            run_cnt_d = run_cnt_q + 1'b1;
        ptr_d     = (cur_q == LAST_CH) ? '0 : cur_q + 1'b1;
    end

    // Scheduler FSM with registered control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            ptr_q       <= '0;
            bit_cnt_q   <= '0;
            run_cnt_q   <= '0;
            gnt_q       <= '0;
            det_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if ((state_q == ST_CLR || state_q == ST_RUN || state_q == ST_DRAIN) && !cur_req) begin
                // Granted requester withdrew: drop the frame, keep last result.
                state_q   <= ST_IDLE;
                abort_q   <= 1'b1;
                gnt_q     <= '0;
                det_rst_q <= 1'b1;
                ptr_q     <= ptr_d;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        gnt_q     <= '0;
                        det_rst_q <= 1'b1;
                        if (arb_any) begin
                            cur_q   <= arb_id;
                            gnt_q   <= arb_gnt;
                            state_q <= ST_CLR;
                        end
                    end
                    ST_CLR: begin
                        bit_cnt_q <= '0;
                        run_cnt_q <= '0;
                        det_rst_q <= 1'b0;
                        state_q   <= ST_RUN;
                    end
                    ST_RUN: begin
                        run_cnt_q <= run_cnt_d;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            gnt_q     <= '0;
                            if (DET_LAT > 0) begin
                                state_q <= ST_DRAIN;
                            end else begin
                                state_q     <= ST_DONE;
                                done_q      <= 1'b1;
                                done_id_q   <= cur_q;
                                match_cnt_q <= run_cnt_d;
                                ptr_q       <= ptr_d;
                                det_rst_q   <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 8'd1;
                        end
                    end
                    ST_DRAIN: begin
                        run_cnt_q <= run_cnt_d;
                        if (bit_cnt_q == LAST_DRAIN) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            done_id_q   <= cur_q;
                            match_cnt_q <= run_cnt_d;
                            ptr_q       <= ptr_d;
                            det_rst_q   <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 8'd1;
                        end
                    end
                    ST_DONE: begin
                        state_q   <= ST_IDLE;
                        det_rst_q <= 1'b1;
                        gnt_q     <= '0;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        gnt_q     <= '0;
                        det_rst_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign det_x     = (state_q == ST_RUN) && bit_in[cur_q];
    assign gnt       = gnt_q;
    assign det_rst   = det_rst_q;
    assign done      = done_q;
    assign abort     = abort_q;
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: two scheduler instances (full-width and a
// 2-bit saturating counter) each driving a behavioural 1010 detector.
// Stimulus pushes expected frame results; a monitor pops them on done/abort.
module tb_seq_det_sched;

    localparam int N  = 4;
    localparam int FL = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] bit_in;

    logic [N-1:0] gnt, gnt2;
    logic         det_x, det_x2, det_rst, det_rst2;
    logic         det_z, det_z2;
    logic         done, done2, abort, abort2;
    logic [1:0]   done_id, done_id2;
    logic [4:0]   match_cnt;
    logic [1:0]   match_cnt2;

    always #5 clk = ~clk;

    seq_det_sched #(.N_CH(4), .FRAME_LEN(16), .DET_LAT(1), .CNT_W(5), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .gnt(gnt),
        .det_x(det_x), .det_rst(det_rst), .det_z(det_z), .done(done),
        .done_id(done_id), .match_cnt(match_cnt), .abort(abort)
    );

    seq_det_sched #(.N_CH(4), .FRAME_LEN(16), .DET_LAT(1), .CNT_W(2), .ID_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .gnt(gnt2),
        .det_x(det_x2), .det_rst(det_rst2), .det_z(det_z2), .done(done2),
        .done_id(done_id2), .match_cnt(match_cnt2), .abort(abort2)
    );

    // Behavioural Moore 1010 detectors (z registered, one cycle after x).
    logic [2:0] h1 = '0, h2 = '0;
    logic       z1 = 1'b0, z2 = 1'b0;
    always @(posedge clk) begin
        if (det_rst) begin h1 <= '0; z1 <= 1'b0; end
        else begin h1 <= {h1[1:0], det_x}; z1 <= ({h1, det_x} == 4'b1010); end
    end
    always @(posedge clk) begin
        if (det_rst2) begin h2 <= '0; z2 <= 1'b0; end
        else begin h2 <= {h2[1:0], det_x2}; z2 <= ({h2, det_x2} == 4'b1010); end
    end
    assign det_z  = z1;
    assign det_z2 = z2;

    typedef struct {
        bit is_abort;
        int id;
        int cnt;
        int cnt2;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // Per-cycle expectations, written by stimulus at the falling edge.
    logic [N-1:0] exp_gnt;
    logic         exp_det_rst, exp_det_x, exp_done, exp_abort;

    // Reference state of the high-level model.
    int ptr = 0;
    int last_id = 0, last_cnt = 0, last_cnt2 = 0;
    bit pending_abort = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Overlapping occurrences of 1010 in a stream written first-bit-left.
    function automatic int count1010(input logic [FL-1:0] s);
        int n = 0;
        for (int p = 0; p <= FL - 4; p++)
            if (s[FL-1-p -: 4] == 4'b1010) n++;
        return n;
    endfunction

    function automatic int pick(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++)
            if (mask[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    // Monitor: per-cycle protocol compare and scoreboard pop on results.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            check("cycle",
                  {14'd0, gnt, det_rst, det_x, done, abort, gnt2, det_rst2, det_x2, done2, abort2},
                  {14'd0, exp_gnt, exp_det_rst, exp_det_x, exp_done, exp_abort,
                   exp_gnt, exp_det_rst, exp_det_x, exp_done, exp_abort});
            if (done || abort) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard: unexpected done=%0b abort=%0b with nothing expected", done, abort);
                end else begin
                    e = exp_q.pop_front();
                    check("kind", {31'd0, abort}, {31'd0, e.is_abort});
                    check("done_id", {30'd0, done_id}, e.id);
                    check("match_cnt", {27'd0, match_cnt}, e.cnt);
                    check("match_cnt_sat", {30'd0, match_cnt2}, e.cnt2);
                    $display("[TB] %s ch=%0d cnt=%0d sat_cnt=%0d", abort ? "abort" : "done ",
                             done_id, match_cnt, match_cnt2);
                end
            end
        end
    end

    task automatic set_idle_exp();
        exp_gnt     = '0;
        exp_det_rst = 1'b1;
        exp_det_x   = 1'b0;
        exp_done    = 1'b0;
        exp_abort   = pending_abort;
        pending_abort = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req    = '0;
            bit_in = N'($urandom);
            set_idle_exp();
            @(negedge clk);
        end
    endtask

    // Runs one frame starting in an IDLE cycle; returns at the falling edge
    // of the following IDLE cycle. abort_at: RUN index 0..FL-1 or FL for DRAIN.
    task automatic run_frame(input logic [N-1:0] mask, input logic [FL-1:0] st [N],
                             input int abort_at, input int rst_at);
        int cur, cnt, cnt2;
        exp_t e;
        cur  = pick(mask);
        cnt  = count1010(st[cur]);
        cnt2 = (cnt > 3) ? 3 : cnt;
        if (abort_at >= 0) begin
            e = '{1'b1, last_id, last_cnt, last_cnt2};
            exp_q.push_back(e);
        end else if (rst_at < 0) begin
            e = '{1'b0, cur, cnt, cnt2};
            exp_q.push_back(e);
            last_id = cur; last_cnt = cnt; last_cnt2 = cnt2;
        end
        // IDLE
        req    = mask;
        bit_in = '0;
        set_idle_exp();
        @(negedge clk);
        // CLR
        exp_gnt   = N'(1 << cur);
        exp_abort = 1'b0;
        @(negedge clk);
        // RUN
        for (int k = 0; k < FL; k++) begin
            for (int c = 0; c < N; c++) bit_in[c] = st[c][FL-1-k];
            exp_gnt     = N'(1 << cur);
            exp_det_rst = 1'b0;
            exp_det_x   = st[cur][FL-1-k];
            if (k == rst_at) begin
                rst         = 1'b0;
                exp_gnt     = '0;
                exp_det_rst = 1'b1;
                exp_det_x   = 1'b0;
                #2;
                check("rst_async_done_id", {30'd0, done_id}, 0);
                check("rst_async_match_cnt", {27'd0, match_cnt}, 0);
                @(negedge clk);
                rst = 1'b1;
                req = '0;
                bit_in = '0;
                ptr = 0; last_id = 0; last_cnt = 0; last_cnt2 = 0;
                pending_abort = 0;
                return;
            end
            if (k == abort_at) begin
                req[cur] = 1'b0;
                @(negedge clk);
                ptr = (cur + 1) % N;
                pending_abort = 1;
                return;
            end
            @(negedge clk);
        end
        // DRAIN
        bit_in    = '0;
        exp_gnt   = '0;
        exp_det_x = 1'b0;
        if (abort_at == FL) begin
            req[cur] = 1'b0;
            @(negedge clk);
            ptr = (cur + 1) % N;
            pending_abort = 1;
            return;
        end
        @(negedge clk);
        // DONE
        exp_det_rst = 1'b1;
        exp_done    = 1'b1;
        @(negedge clk);
        exp_done = 1'b0;
        ptr = (cur + 1) % N;
    endtask

    function automatic logic [FL-1:0] rand_stream();
        logic [FL-1:0] r;
        r = FL'($urandom);
        if ($urandom_range(0, 1) == 1)
            r = 16'b1010_1010_1010_1010 ^ (r & FL'($urandom) & FL'($urandom));
        return r;
    endfunction

    initial begin
        logic [FL-1:0] st [N];
        logic [N-1:0]  mask;
        int            ab;

        rst = 1'b0;
        req = '0;
        bit_in = '0;
        exp_gnt = '0; exp_det_rst = 1'b1; exp_det_x = 1'b0; exp_done = 1'b0; exp_abort = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_done_id", {30'd0, done_id}, 0);
        check("reset_match_cnt", {27'd0, match_cnt}, 0);
        check("reset_match_cnt_sat", {30'd0, match_cnt2}, 0);
        rst = 1'b1;

        // All channels requesting: grants rotate 0,1,2,3,0.
        for (int f = 0; f < 5; f++) begin
            for (int c = 0; c < N; c++) st[c] = rand_stream();
            run_frame(4'b1111, st, -1, -1);
        end

        // Single requesters with fixed streams.
        for (int c = 0; c < N; c++) st[c] = rand_stream();
        st[0] = 16'b1010_1010_0000_0000;
        run_frame(4'b0001, st, -1, -1);
        st[1] = 16'b1010_1010_1010_1010;
        run_frame(4'b0010, st, -1, -1);
        st[1] = 16'b0000_0000_0000_0000;
        run_frame(4'b0010, st, -1, -1);
        st[1] = 16'b1111_0000_1111_0000;
        run_frame(4'b0010, st, -1, -1);

        // Channel 2 withdraws in RUN cycle 5; channel 3 gets the next grant.
        for (int c = 0; c < N; c++) st[c] = rand_stream();
        run_frame(4'b1100, st, 5, -1);
        run_frame(4'b1100, st, -1, -1);

        // Reset during RUN cycle 8, then a normal frame.
        st[0] = 16'b1010_1010_1010_1010;
        run_frame(4'b0001, st, -1, 8);
        idle_cycles(1);
        run_frame(4'b0001, st, -1, -1);

        // Randomised frames with occasional aborts and idle gaps.
        for (int f = 0; f < 40; f++) begin
            for (int c = 0; c < N; c++) st[c] = rand_stream();
            mask = N'($urandom_range(1, 15));
            ab   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, FL)) : -1;
            run_frame(mask, st, ab, -1);
            if ($urandom_range(0, 4) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end

        idle_cycles(3);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
